prog_streamer: RTL and testbench

Host-side program loader that drives the processor's `data_in`/`start` load port. It buffers opcode/operand pairs written by a host, then streams them into the processor's WRITE-phase byte protocol: start address, then alternating instruction and data bytes, one per clock. It finally raises `start` to hand control to execution. It sits between the test/host interface and the processor, and is the transmitting end of the processor's program-load interface.

---
 rtl/prog_streamer.sv | 165 ++++++++++++++++
 tb/tb_prog_streamer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/prog_streamer.sv
// Host-side program loader: buffers opcode/operand pairs, then streams address,
// opcode and operand bytes into the processor load port and raises start.
// Optional HALT append controlled by `define PROG_STREAMER_HALT_APPEND_EN.
module prog_streamer #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [3:0]    wr_op,
   input  logic [7:0]    wr_arg,
   input  logic [7:0]    base_addr,
   input  logic          go,
   input  logic          stop,
   output logic          busy,
   output logic          done,
   output logic          full,
   output logic          overflow,
   output logic [AW:0]   count,
   output logic [7:0]    proc_data,
   output logic          proc_start
);

   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
   localparam logic [7:0]  HALT_OP    = 8'h08;

`ifdef PROG_STREAMER_HALT_APPEND_EN
   localparam logic HALT_EN = 1'b1;
`else
   localparam logic HALT_EN = 1'b0;
`endif

   typedef enum logic [2:0] {IDLE, ADDR, OP, ARG, RUN} state_t;

   state_t            state;
   logic [11:0]       mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW-1:0]     rd_next;
   logic [AW:0]       sent;
   logic [7:0]        base_q;
   logic              halt_phase;
   logic              push_ok;
   logic              more_pairs;

   assign push_ok    = (state == IDLE) && wr_en && (count < FULL_COUNT);
   assign rd_next    = rd_ptr + 1'b1;
   assign more_pairs = (sent + 1'b1) < count;

   // Buffer storage carries no reset; count alone says which entries are valid.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= {wr_op, wr_arg};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         sent       <= '0;
         base_q     <= '0;
         halt_phase <= 1'b0;
         count      <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         full       <= 1'b0;
         overflow   <= 1'b0;
         proc_data  <= '0;
         proc_start <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               // A push in the same cycle as go lands first and joins the stream.
               if (push_ok) begin
                  wr_ptr <= wr_ptr + 1'b1;
                  count  <= count + 1'b1;
                  full   <= ((count + 1'b1) == FULL_COUNT);
               end else if (wr_en) begin
                  overflow <= 1'b1;
               end
               if (go) begin
                  base_q     <= base_addr;
                  rd_ptr     <= '0;
                  sent       <= '0;
                  halt_phase <= 1'b0;
                  proc_data  <= base_addr;
                  busy       <= 1'b1;
                  state      <= ADDR;
               end
            end

            ADDR: begin
               if (count == '0) begin
                  if (HALT_EN) begin
                     halt_phase <= 1'b1;
                     proc_data  <= HALT_OP;
                     state      <= OP;
                  end else begin
                     proc_start <= 1'b1;
                     done       <= 1'b1;
                     proc_data  <= base_q;
                     state      <= RUN;
                  end
               end else begin
                  proc_data <= {4'h0, mem[rd_ptr][11:8]};
                  state     <= OP;
               end
            end

            OP: begin
               proc_data <= halt_phase ? 8'h00 : mem[rd_ptr][7:0];
               state     <= ARG;
            end

            ARG: begin
               if (halt_phase) begin
                  proc_start <= 1'b1;
                  done       <= 1'b1;
                  proc_data  <= base_q;
                  state      <= RUN;
               end else begin
                  rd_ptr <= rd_next;
                  sent   <= sent + 1'b1;
                  if (more_pairs) begin
                     proc_data <= {4'h0, mem[rd_next][11:8]};
                     state     <= OP;
                  end else if (HALT_EN) begin
                     halt_phase <= 1'b1;
                     proc_data  <= HALT_OP;
                     state      <= OP;
                  end else begin
                     proc_start <= 1'b1;
                     done       <= 1'b1;
                     proc_data  <= base_q;
                     state      <= RUN;
                  end
               end
            end

            RUN: begin
               if (stop) begin
                  state      <= IDLE;
                  busy       <= 1'b0;
                  proc_start <= 1'b0;
                  proc_data  <= '0;
                  count      <= '0;
                  full       <= 1'b0;
                  overflow   <= 1'b0;
                  wr_ptr     <= '0;
                  rd_ptr     <= '0;
                  sent       <= '0;
                  halt_phase <= 1'b0;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_prog_streamer.sv
// Directed bench for prog_streamer: loads programs, follows the byte stream
// cycle by cycle and compares against hand-computed bytes.
module tb_prog_streamer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       wr_en = 1'b0;
   logic [3:0] wr_op = '0;
   logic [7:0] wr_arg = '0;
   logic [7:0] base_addr = '0;
   logic       go = 1'b0;
   logic       stop = 1'b0;
   logic       busy, done, full, overflow, proc_start;
   logic [4:0] count;
   logic [7:0] proc_data;

   int errors = 0;
   int checks = 0;

   logic [3:0] eop  [16];
   logic [7:0] earg [16];

   always #5 clk = ~clk;

   prog_streamer #(.DEPTH(16), .AW(4)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_op(wr_op), .wr_arg(wr_arg),
      .base_addr(base_addr), .go(go), .stop(stop), .busy(busy), .done(done),
      .full(full), .overflow(overflow), .count(count), .proc_data(proc_data),
      .proc_start(proc_start)
   );

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] simulation did not finish");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic setInputs(input logic we, input logic [3:0] op, input logic [7:0] arg,
                            input logic g, input logic [7:0] base, input logic s);
      wr_en = we; wr_op = op; wr_arg = arg; go = g; base_addr = base; stop = s;
   endtask

   task automatic applyStimulus(input logic we, input logic [3:0] op, input logic [7:0] arg,
                                input logic g, input logic [7:0] base, input logic s);
      setInputs(we, op, arg, g, base, s);
      tick();
      setInputs(1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic pushPair(input logic [3:0] op, input logic [7:0] arg);
      applyStimulus(1'b1, op, arg, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic goLoad(input logic [7:0] base);
      applyStimulus(1'b0, 4'h0, 8'h00, 1'b1, base, 1'b0);
   endtask

   // Called just after the edge that accepted go; follows the whole stream into RUN.
   task automatic streamCheck(input logic [7:0] base, input int n, input bit disturb,
                              input logic [4:0] exp_count);
      checkOutput("addr_data", proc_data, base);
      checkOutput("addr_busy", busy, 1'b1);
      checkOutput("addr_start", proc_start, 1'b0);
      if (disturb) setInputs(1'b1, 4'hF, 8'hEE, 1'b1, 8'hFF, 1'b1);
      for (int k = 0; k < n; k++) begin
         tick();
         checkOutput($sformatf("op%0d", k), proc_data, {4'h0, eop[k]});
         checkOutput("op_start", proc_start, 1'b0);
         checkOutput("op_count", count, exp_count);
         tick();
         checkOutput($sformatf("arg%0d", k), proc_data, earg[k]);
         checkOutput("arg_done", done, 1'b0);
      end
`ifdef PROG_STREAMER_HALT_APPEND_EN
      tick();
      checkOutput("halt_op", proc_data, 8'h08);
      tick();
      checkOutput("halt_arg", proc_data, 8'h00);
`endif
      tick();
      setInputs(1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 1'b0);
      checkOutput("run_start", proc_start, 1'b1);
      checkOutput("run_data", proc_data, base);
      checkOutput("run_done", done, 1'b1);
      checkOutput("run_count", count, exp_count);
      tick();
      checkOutput("run_done_drop", done, 1'b0);
      checkOutput("run_start_hold", proc_start, 1'b1);
      checkOutput("run_data_hold", proc_data, base);
   endtask

   task automatic stopRun;
      applyStimulus(1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 1'b1);
      checkOutput("stop_busy", busy, 1'b0);
      checkOutput("stop_count", count, 5'd0);
      checkOutput("stop_overflow", overflow, 1'b0);
      checkOutput("stop_full", full, 1'b0);
      checkOutput("stop_start", proc_start, 1'b0);
   endtask

   initial begin
      // Reset values
      #12;
      checkOutput("rst_data", proc_data, 8'h00);
      checkOutput("rst_start", proc_start, 1'b0);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_done", done, 1'b0);
      checkOutput("rst_full", full, 1'b0);
      checkOutput("rst_overflow", overflow, 1'b0);
      checkOutput("rst_count", count, 5'd0);
      rst = 1'b1;
      tick();

      $display("[TB] basic three-pair load");
      pushPair(4'h1, 8'h05);
      pushPair(4'h2, 8'h07);
      pushPair(4'h3, 8'h00);
      checkOutput("basic_count", count, 5'd3);
      eop[0] = 4'h1; earg[0] = 8'h05;
      eop[1] = 4'h2; earg[1] = 8'h07;
      eop[2] = 4'h3; earg[2] = 8'h00;
      goLoad(8'h10);
      streamCheck(8'h10, 3, 1'b0, 5'd3);
      stopRun();

      $display("[TB] fill to capacity and overflow");
      for (int i = 0; i < 16; i++) begin
         eop[i]  = 4'(15 - i);
         earg[i] = 8'(i * 7 + 3);
         pushPair(eop[i], earg[i]);
      end
      checkOutput("fill_full", full, 1'b1);
      checkOutput("fill_count", count, 5'd16);
      checkOutput("fill_overflow", overflow, 1'b0);
      pushPair(4'hC, 8'hCC);
      checkOutput("ovf_overflow", overflow, 1'b1);
      checkOutput("ovf_count", count, 5'd16);
      checkOutput("ovf_full", full, 1'b1);
      goLoad(8'h20);
      streamCheck(8'h20, 16, 1'b0, 5'd16);
      stopRun();

      $display("[TB] empty load");
      goLoad(8'h33);
      streamCheck(8'h33, 0, 1'b0, 5'd0);
      stopRun();

      $display("[TB] writes, go and stop during stream are ignored");
      pushPair(4'h4, 8'hA4);
      pushPair(4'h9, 8'h9B);
      eop[0] = 4'h4; earg[0] = 8'hA4;
      eop[1] = 4'h9; earg[1] = 8'h9B;
      goLoad(8'h44);
      streamCheck(8'h44, 2, 1'b1, 5'd2);
      stopRun();

      $display("[TB] push and go in the same cycle");
      pushPair(4'h6, 8'h61);
      applyStimulus(1'b1, 4'h7, 8'h72, 1'b1, 8'h50, 1'b0);
      eop[0] = 4'h6; earg[0] = 8'h61;
      eop[1] = 4'h7; earg[1] = 8'h72;
      streamCheck(8'h50, 2, 1'b0, 5'd2);
      stopRun();

      $display("[TB] asynchronous reset mid-stream");
      pushPair(4'hA, 8'h1A);
      pushPair(4'hB, 8'h2B);
      goLoad(8'h60);
      tick();
      tick();
      checkOutput("mid_arg_data", proc_data, 8'h1A);
      #2 rst = 1'b0;
      #1;
      checkOutput("arst_data", proc_data, 8'h00);
      checkOutput("arst_start", proc_start, 1'b0);
      checkOutput("arst_busy", busy, 1'b0);
      checkOutput("arst_count", count, 5'd0);
      checkOutput("arst_done", done, 1'b0);
      #1 rst = 1'b1;
      tick();
      checkOutput("post_rst_count", count, 5'd0);
      checkOutput("post_rst_busy", busy, 1'b0);
      pushPair(4'h5, 8'h55);
      eop[0] = 4'h5; earg[0] = 8'h55;
      goLoad(8'h70);
      streamCheck(8'h70, 1, 1'b0, 5'd1);
      stopRun();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
